deserializer: RTL

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_if.sv | 11 +
 rtl/deserializer.sv | 82 ++++++++
 2 files changed

// File: rtl/deserializer_if.sv
// Valid/accept/data channel; the producer owns v and d, the consumer owns a.
interface deserializer_if #(
  parameter int W = 1
);
  logic         v;
  logic         a;
  logic [W-1:0] d;

  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

// File: rtl/deserializer.sv
// Packs D consecutive Nin-bit input words (LSB word first) into one Nout-bit
// output word, holding the assembled word until the consumer accepts it.
module deserializer #(
  parameter int Nin  = 1,
  parameter int Nout = 2
) (
  input  logic clk,
  input  logic reset,
  deserializer_if.slave  in,
  deserializer_if.master out
);

  localparam int D  = (Nout + Nin - 1) / Nin;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [Nout-1:0]   buf_q, buf_d;
  logic              wr;
  // Full D*Nin-bit view; bits above Nout (the discarded top of the last word) are dropped.
  logic [D*Nin-1:0]  assembled_unused;

  always_comb begin
    assembled_unused             = '0;
    assembled_unused[Nout-1:0]   = buf_q;
    assembled_unused[int'(cnt_q)*Nin +: Nin] = in.d;
    buf_d                        = assembled_unused[Nout-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    in.a    = 1'b1;
    out.v   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (in.v) begin
          wr = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        out.v = 1'b1;
        in.a  = out.a;
        if (out.a) begin
          state_d = COLLECT;
          // Input accepted alongside the output transfer starts the next group at slot 0.
          if (in.v) begin
            wr = 1'b1;
            if (D == 1) state_d = HOLD;
            else        cnt_d   = CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr) buf_q <= buf_d;
    end
  end

  assign out.d = buf_q;

endmodule
